operand_fetch: RTL

- Sequencer that sits directly downstream of the constant ROM (`const`) and the data RAM, and directly upstream of the GF(3^m) arithmetic unit.
- On a start command it resolves two 6-bit operand addresses into two 198-bit operand registers.
- Each address goes to the constant ROM first. If the ROM reports the address as non-effective, the word is read from the data RAM instead.
- Pulses done when both operands are loaded.

---
 rtl/operand_fetch_pkg.sv | 41 ++++
 rtl/operand_fetch_slot.sv | 92 +++++++++
 rtl/operand_fetch.sv | 114 +++++++++++
 3 files changed

// File: rtl/operand_fetch_pkg.sv
// Shared definitions for the operand fetch sequencer: default widths,
// FSM encodings and the well-known constant ROM addresses.
package operand_fetch_pkg;

    localparam int WIDTH_DEF = 198;
    localparam int AW_DEF    = 6;

    // Top-level sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_A_ROM = 3'd1;
    localparam logic [2:0] ST_A_CHK = 3'd2;
    localparam logic [2:0] ST_A_RAM = 3'd3;
    localparam logic [2:0] ST_B_ROM = 3'd4;
    localparam logic [2:0] ST_B_CHK = 3'd5;
    localparam logic [2:0] ST_B_RAM = 3'd6;
    localparam logic [2:0] ST_DONE  = 3'd7;

    // Single-slot resolver states
    localparam logic [1:0] SL_IDLE = 2'd0;
    localparam logic [1:0] SL_ROM  = 2'd1;
    localparam logic [1:0] SL_CHK  = 2'd2;
    localparam logic [1:0] SL_RAM  = 2'd3;

    // Constant ROM addresses that hold effective words
    localparam logic [5:0] ADDR_ZERO  = 6'd1;
    localparam logic [5:0] ADDR_ONE   = 6'd2;
    localparam logic [5:0] ADDR_PLUS  = 6'd4;
    localparam logic [5:0] ADDR_MINUS = 6'd8;
    localparam logic [5:0] ADDR_CUBIC = 6'd16;

    // True while the sequencer is resolving operand A
    function automatic logic is_a_phase(input logic [2:0] st);
        return (st == ST_A_ROM) || (st == ST_A_CHK) || (st == ST_A_RAM);
    endfunction

    // True while the sequencer is resolving operand B
    function automatic logic is_b_phase(input logic [2:0] st);
        return (st == ST_B_ROM) || (st == ST_B_CHK) || (st == ST_B_RAM);
    endfunction

endpackage

// File: rtl/operand_fetch_slot.sv
// Resolves one address: tries the constant ROM, falls back to the data RAM
// when the ROM word is not effective. A new request may be accepted in the
// same cycle the previous one is acknowledged, so back-to-back operands
// flow without a bubble.
module fetch_slot
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [AW-1:0]    addr,
    output logic             ack,
    output logic [WIDTH-1:0] data,
    output logic [AW-1:0]    const_addr,
    input  logic [WIDTH-1:0] const_out,
    input  logic             const_eff,
    output logic             ram_rd,
    output logic [AW-1:0]    ram_addr,
    input  logic [WIDTH-1:0] ram_dout
);

    logic [1:0]    st;
    logic [1:0]    st_nxt;
    logic [AW-1:0] addr_q;

    // Next-state logic for the ROM-then-RAM resolution
    always_comb begin
        st_nxt = st;
        case (st)
            SL_IDLE: begin
                if (req) st_nxt = SL_ROM;
                else     st_nxt = SL_IDLE;
            end
            SL_ROM:  st_nxt = SL_CHK;
            SL_CHK: begin
                if (!const_eff) st_nxt = SL_RAM;
                else if (req)   st_nxt = SL_ROM;
                else            st_nxt = SL_IDLE;
            end
            SL_RAM: begin
                if (req) st_nxt = SL_ROM;
                else     st_nxt = SL_IDLE;
            end
            default: st_nxt = SL_IDLE;
        endcase
    end

    // State and latched address; the address is captured only on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            st     <= SL_IDLE;
            addr_q <= {AW{1'b0}};
        end else begin
            st <= st_nxt;
            if (req && (st_nxt == SL_ROM)) addr_q <= addr;
            else                           addr_q <= addr_q;
        end
    end

    // Memory-side strobes and result path; idle values are all zero
    always_comb begin
        const_addr = {AW{1'b0}};
        ram_rd     = 1'b0;
        ram_addr   = {AW{1'b0}};
        ack        = 1'b0;
        data       = {WIDTH{1'b0}};
        case (st)
            SL_ROM: const_addr = addr_q;
            SL_CHK: begin
                const_addr = addr_q;
                if (const_eff) begin
                    ack  = 1'b1;
                    data = const_out;
                end else begin
                    ram_rd   = 1'b1;
                    ram_addr = addr_q;
                end
            end
            SL_RAM: begin
                ack  = 1'b1;
                data = ram_dout;
            end
            default: begin
                const_addr = {AW{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch sequencer: on start, resolves operand A then operand B
// through one shared fetch slot and pulses done once both are loaded.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW-1:0]    addr_a,
    input  logic [AW-1:0]    addr_b,
    output logic [AW-1:0]    const_addr,
    input  logic [WIDTH-1:0] const_out,
    input  logic             const_eff,
    output logic             ram_rd,
    output logic [AW-1:0]    ram_addr,
    input  logic [WIDTH-1:0] ram_dout,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done
);

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [AW-1:0]    addr_b_q;
    logic             slot_req;
    logic [AW-1:0]    slot_addr;
    logic             slot_ack;
    logic [WIDTH-1:0] slot_data;

    // Request A on start acceptance, and B in the same cycle A completes
    always_comb begin
        slot_req  = 1'b0;
        slot_addr = addr_b_q;
        if (state == ST_IDLE) begin
            slot_req  = start;
            slot_addr = addr_a;
        end else begin
            slot_req  = slot_ack && is_a_phase(state);
            slot_addr = addr_b_q;
        end
    end

    fetch_slot #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_slot (
        .clk        (clk),
        .reset      (reset),
        .req        (slot_req),
        .addr       (slot_addr),
        .ack        (slot_ack),
        .data       (slot_data),
        .const_addr (const_addr),
        .const_out  (const_out),
        .const_eff  (const_eff),
        .ram_rd     (ram_rd),
        .ram_addr   (ram_addr),
        .ram_dout   (ram_dout)
    );

    // Sequencer next-state: A then B, each CHK exits early on a ROM hit
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_A_ROM;
                else       state_nxt = ST_IDLE;
            end
            ST_A_ROM: state_nxt = ST_A_CHK;
            ST_A_CHK: begin
                if (slot_ack) state_nxt = ST_B_ROM;
                else          state_nxt = ST_A_RAM;
            end
            ST_A_RAM: state_nxt = ST_B_ROM;
            ST_B_ROM: state_nxt = ST_B_CHK;
            ST_B_CHK: begin
                if (slot_ack) state_nxt = ST_DONE;
                else          state_nxt = ST_B_RAM;
            end
            ST_B_RAM: state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State, latched B address and operand registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            addr_b_q <= {AW{1'b0}};
            op_a     <= {WIDTH{1'b0}};
            op_b     <= {WIDTH{1'b0}};
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && start) addr_b_q <= addr_b;
            else                             addr_b_q <= addr_b_q;
            if (slot_ack && is_a_phase(state)) op_a <= slot_data;
            else                               op_a <= op_a;
            if (slot_ack && is_b_phase(state)) op_b <= slot_data;
            else                               op_b <= op_b;
        end
    end

    // Status flags decoded straight from the state register
    always_comb begin
        busy = (state != ST_IDLE) && (state != ST_DONE);
        done = (state == ST_DONE);
    end

endmodule
